// File: rtl/uart_tx_buffered_pkg.sv
// ----------------------------------------------------------------------------
// uart_tx_buffered_pkg
//
// Shared definitions for the buffered 8N1 UART transmitter.
//   tx_state_t : 2-bit serialiser FSM state encoding (IDLE, START, DATA, STOP)
//   FRAME_BITS : serial bits per frame (start + 8 data + stop)
//   DATA_BITS  : payload bits per frame
// ----------------------------------------------------------------------------
package uart_tx_buffered_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/sync_fifo_8.sv
// ----------------------------------------------------------------------------
// sync_fifo_8
//
// Single-clock byte FIFO feeding the UART serialiser.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, empties the FIFO
//   i_push   : enqueue i_data (ignored while full)
//   i_data   : byte to enqueue
//   i_pop    : dequeue the head entry (ignored while empty)
//   o_data   : head entry, valid while not empty
//   o_count  : current occupancy, 0..DEPTH
//   o_full   : occupancy equals DEPTH
//   o_empty  : occupancy is zero
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ----------------------------------------------------------------------------
module sync_fifo_8 #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    // full/empty come straight from the occupancy register, so a push that
    // arrives while full is dropped even if a pop frees a slot that same edge
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array; no reset needed because reads are qualified by occupancy
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves
    // the occupancy unchanged while both pointers advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered 8N1 UART transmitter. Bytes written by the core are queued in a
// small FIFO and serialised LSB-first at CLKS_PER_BIT clocks per bit, with
// queued bytes sent back-to-back (no idle cycle between frames).
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset; line forced high, FIFO emptied
//   wr_data  : byte to enqueue
//   wr_en    : enqueue strobe
//   full     : FIFO holds FIFO_DEPTH entries
//   count    : FIFO occupancy
//   busy     : a frame (start..stop) is in progress
//   uart_tx  : registered serial line, idles high
// ----------------------------------------------------------------------------
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_en,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          uart_tx
);

    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t    r_state;
    tx_state_t    w_state_next;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_next;
    logic [2:0]   r_bit_idx;
    logic [2:0]   w_bit_idx_next;
    logic [7:0]   r_shift;
    logic [7:0]   w_shift_next;
    logic         r_tx;
    logic         w_tx_next;
    logic         w_baud_end;
    logic         w_pop;
    logic         w_fifo_empty;
    logic [7:0]   w_fifo_data;

    sync_fifo_8 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (count),
        .o_full  (full),
        .o_empty (w_fifo_empty)
    );

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign busy       = (r_state != ST_IDLE);
    assign uart_tx    = r_tx;

    // Next-state logic for the serialiser. Each non-idle state holds for one
    // full baud period and advances on the last count. The end of the stop
    // bit behaves like IDLE: if anything is queued it is popped straight into
    // a new start bit so frames run back-to-back. The line value is computed
    // for the state being entered so the registered output lines up with it.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = r_baud;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        w_tx_next      = 1'b1;

        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_data;
                    w_baud_next  = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_baud_next    = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = ST_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_data;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    // State, counters, shift register and the registered serial line.
    // Reset drops any partial frame and forces the line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

endmodule
